// File: rtl/icache.sv
// Direct-mapped instruction cache: 2^IDX_W lines of 16 bytes.
// A hit returns its word one cycle after the request. A miss issues a
// line fill and returns to IDLE when the fill lands; the held request
// is then looked up again. A flush during a fill moves to DROP, which
// waits for the outstanding fill and then discards it.
module icache #(
  parameter int IDX_W = 6,
  parameter int TAG_W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic         if_valid,
  input  logic [31:0]  if_addr,
  output logic         if_done,
  output logic [31:0]  if_inst,
  output logic         icache_fc_valid,
  output logic [31:0]  icache_fc_addr,
  input  logic         icache_fc_done,
  input  logic [127:0] icache_fc_line
);

  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, MISS, DROP} state_t;

  state_t state, state_nxt;

  // Line storage: valid bits are control state, tag/data are plain arrays
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [127:0]     data_mem [LINES];

  // Lookup of the current request (combinational, stage p0)
  logic [IDX_W-1:0] req_idx_p0;
  logic [TAG_W-1:0] req_tag_p0;
  logic [127:0]     req_line_p0;
  logic [31:0]      hit_word_p0;
  logic             hit_p0;

  // Fill target comes from the registered fill address
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;

  // Control decisions made by the FSM for this cycle
  logic fill_we;
  logic clr_valid;
  logic done_nxt;
  logic inst_we;
  logic fc_start;
  logic fc_end;

  // Byte-offset bits [1:0] never select anything
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[1:0], icache_fc_addr[3:0]};

  assign req_idx_p0  = if_addr[IDX_W+3:4];
  assign req_tag_p0  = if_addr[31:IDX_W+4];
  assign req_line_p0 = data_mem[req_idx_p0];
  assign hit_word_p0 = req_line_p0[{if_addr[3:2], 5'b0} +: 32];
  assign hit_p0      = valid[req_idx_p0] && (tag_mem[req_idx_p0] == req_tag_p0);

  assign fill_idx = icache_fc_addr[IDX_W+3:4];
  assign fill_tag = icache_fc_addr[31:IDX_W+4];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and per-cycle control; fill completion ignores rdy
  always_comb begin
    state_nxt = state;
    fill_we   = 1'b0;
    clr_valid = 1'b0;
    done_nxt  = 1'b0;
    inst_we   = 1'b0;
    fc_start  = 1'b0;
    fc_end    = 1'b0;
    case (state)
      IDLE: begin
        if (rdy) begin
          if (flush) begin
            clr_valid = 1'b1;
          end else if (if_valid) begin
            if (hit_p0) begin
              done_nxt = 1'b1;
              inst_we  = 1'b1;
            end else begin
              fc_start  = 1'b1;
              state_nxt = MISS;
            end
          end
        end
      end
      MISS: begin
        if (icache_fc_done) begin
          fc_end    = 1'b1;
          state_nxt = IDLE;
          if (rdy && flush) clr_valid = 1'b1;
          else              fill_we   = 1'b1;
        end else if (rdy && flush) begin
          clr_valid = 1'b1;
          state_nxt = DROP;
        end
      end
      DROP: begin
        if (icache_fc_done) begin
          fc_end    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers and outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid           <= '0;
      if_done         <= 1'b0;
      if_inst         <= '0;
      icache_fc_valid <= 1'b0;
      icache_fc_addr  <= '0;
    end else begin
      if_done <= done_nxt;
      if (inst_we) if_inst <= hit_word_p0;
      if (clr_valid)    valid           <= '0;
      else if (fill_we) valid[fill_idx] <= 1'b1;
      if (fc_start) begin
        icache_fc_valid <= 1'b1;
        icache_fc_addr  <= {if_addr[31:4], 4'b0};
      end else if (fc_end) begin
        icache_fc_valid <= 1'b0;
      end
    end
  end

  // Tag and data arrays are written only on a kept fill and never reset
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= icache_fc_line;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed fetch scenarios against a line-map model,
// with an automatic memory responder of programmable latency.
`timescale 1ns/1ps
module tb_icache;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rdy;
  logic         flush;
  logic         if_valid;
  logic [31:0]  if_addr;
  logic         if_done;
  logic [31:0]  if_inst;
  logic         icache_fc_valid;
  logic [31:0]  icache_fc_addr;
  logic         icache_fc_done;
  logic [127:0] icache_fc_line;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int mem_lat = 2;
  int fills = 0;
  int fc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  icache dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_valid(if_valid), .if_addr(if_addr),
    .if_done(if_done), .if_inst(if_inst),
    .icache_fc_valid(icache_fc_valid), .icache_fc_addr(icache_fc_addr),
    .icache_fc_done(icache_fc_done), .icache_fc_line(icache_fc_line)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Backing memory contents: line 0x1000 is the reference pattern
  function automatic logic [127:0] mem_line(input logic [31:0] a);
    logic [127:0] l;
    if (a == 32'h0000_1000) l = 128'h0F0E0D0C_DDCCBBAA_44332211_03020100;
    else for (int i = 0; i < 4; i++) l[32*i +: 32] = (a + 32'(4*i)) ^ 32'hC0DE_0000;
    return l;
  endfunction

  // Memory controller: answers a fill mem_lat cycles after it appears
  initial begin : responder
    bit sent;
    int cnt;
    sent = 0;
    cnt = 0;
    icache_fc_done = 1'b0;
    icache_fc_line = '0;
    forever begin
      tick();
      icache_fc_done = 1'b0;
      if (!icache_fc_valid) begin
        sent = 0;
        cnt = 0;
      end else if (!sent) begin
        if (cnt >= mem_lat) begin
          icache_fc_done = 1'b1;
          icache_fc_line = mem_line(icache_fc_addr);
          sent = 1;
          cnt = 0;
          fills++;
          fc_cyc = cyc;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Model: which line address each index holds, plus one pending fill
  bit           m_valid [64];
  logic [27:0]  m_laddr [64];
  logic [127:0] m_data  [64];
  bit           pend;
  bit           pend_drop;
  logic [31:0]  pend_addr;
  logic         exp_done;
  logic [31:0]  exp_inst;
  logic         exp_fcv;
  logic [31:0]  exp_fca;

  task automatic model_clear();
    foreach (m_valid[i]) m_valid[i] = 0;
  endtask

  task automatic model_step();
    int idx;
    if (rst) begin
      model_clear();
      pend = 0; pend_drop = 0; pend_addr = '0;
      exp_done = 1'b0; exp_inst = '0; exp_fcv = 1'b0; exp_fca = '0;
    end else if (pend && icache_fc_done) begin
      if (!pend_drop && !(rdy && flush)) begin
        idx = int'(pend_addr[9:4]);
        m_valid[idx] = 1;
        m_laddr[idx] = pend_addr[31:4];
        m_data[idx]  = icache_fc_line;
      end
      if (rdy && flush) model_clear();
      pend = 0;
      exp_fcv = 1'b0;
      exp_done = 1'b0;
    end else if (!rdy) begin
      exp_done = 1'b0;
    end else if (pend) begin
      exp_done = 1'b0;
      if (flush) begin
        model_clear();
        pend_drop = 1;
      end
    end else begin
      exp_done = 1'b0;
      if (flush) begin
        model_clear();
      end else if (if_valid) begin
        idx = int'(if_addr[9:4]);
        if (m_valid[idx] && m_laddr[idx] == if_addr[31:4]) begin
          exp_done = 1'b1;
          exp_inst = m_data[idx][32*int'(if_addr[3:2]) +: 32];
        end else begin
          pend = 1;
          pend_drop = 0;
          pend_addr = {if_addr[31:4], 4'b0};
          exp_fcv = 1'b1;
          exp_fca = pend_addr;
        end
      end
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clk or posedge rst);
      model_step();
    end
  end

  // Every cycle: outputs against the model, sampled mid-cycle
  initial begin : compare
    forever begin
      @(negedge clk);
      chk("if_done", {31'b0, if_done}, {31'b0, exp_done});
      chk("if_inst", if_inst, exp_inst);
      chk("fc_valid", {31'b0, icache_fc_valid}, {31'b0, exp_fcv});
      chk("fc_addr", icache_fc_addr, exp_fca);
    end
  end

  task automatic wait_done(input int max, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!if_done && lat < max);
    if (!if_done) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: got no if_done, expected one within %0d cycles", max);
    end
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] inst, output int lat,
                       output logic [31:0] fca);
    if_valid = 1'b1;
    if_addr = a;
    lat = 0;
    fca = '0;
    do begin
      tick();
      lat++;
      if (icache_fc_valid && fca == 32'h0) fca = icache_fc_addr;
    end while (!if_done && lat < 200);
    if (!if_done) begin
      vectors++;
      miscompares++;
      $display("FAIL fetch_timeout: got no if_done for %h, expected one", a);
    end
    inst = if_inst;
    if_valid = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, expected end of run");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] inst, fca;
    logic [31:0] ref_w [4];
    int lat, lat2, f0;
    ref_w = '{32'h03020100, 32'h44332211, 32'hDDCCBBAA, 32'h0F0E0D0C};
    rdy = 1'b1; flush = 1'b0; if_valid = 1'b0; if_addr = '0;
    #1 rst = 1'b1;
    repeat (2) tick();
    chk("rst_if_done", {31'b0, if_done}, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_fc_valid", {31'b0, icache_fc_valid}, 32'h0);
    chk("rst_fc_addr", icache_fc_addr, 32'h0);
    rst = 1'b0;
    tick();

    // Cold miss with a two-cycle memory
    mem_lat = 2;
    fetch(32'h0000_1004, inst, lat, fca);
    chk("cold_fc_addr", fca, 32'h0000_1000);
    chk("cold_inst", inst, 32'h44332211);
    chk("cold_latency", 32'(lat), 32'd5);
    chk("cold_after_fc_done", 32'(cyc - fc_cyc), 32'd2);
    tick();

    // Hit stream on consecutive cycles
    if_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if_addr = 32'h0000_1000 + 32'(4*i);
      tick();
      chk("stream_done", {31'b0, if_done}, 32'h1);
      chk("stream_inst", if_inst, ref_w[i]);
      chk("stream_fc_valid", {31'b0, icache_fc_valid}, 32'h0);
    end
    if_valid = 1'b0;
    tick();

    // Stall across a hit stream
    if_valid = 1'b1; if_addr = 32'h0000_1000;
    tick();
    if_valid = 1'b0;
    tick();
    rdy = 1'b0; if_valid = 1'b1; if_addr = 32'h0000_1008;
    repeat (5) begin
      tick();
      chk("stall_done", {31'b0, if_done}, 32'h0);
      chk("stall_inst", if_inst, 32'h03020100);
    end
    rdy = 1'b1;
    tick();
    chk("unstall_done", {31'b0, if_done}, 32'h1);
    chk("unstall_inst", if_inst, 32'hDDCCBBAA);
    if_valid = 1'b0;
    tick();

    // Fill completes while stalled
    mem_lat = 3;
    if_valid = 1'b1; if_addr = 32'h0000_2000;
    tick();
    rdy = 1'b0;
    lat = 0;
    while (icache_fc_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("stall_fill_fc_valid", {31'b0, icache_fc_valid}, 32'h0);
    rdy = 1'b1;
    wait_done(10, lat);
    if_valid = 1'b0;
    tick();
    fetch(32'h0000_2004, inst, lat, fca);
    chk("stall_fill_hit_lat", 32'(lat), 32'd1);
    chk("stall_fill_hit_inst", inst, 32'hC0DE2004);

    // Conflict on index 0
    mem_lat = 2;
    fetch(32'h0000_1400, inst, lat, fca);
    chk("conflict_fc_addr", fca, 32'h0000_1400);
    chk("conflict_lat", 32'(lat), 32'd5);
    fetch(32'h0000_1000, inst, lat, fca);
    chk("refill_fc_addr", fca, 32'h0000_1000);
    chk("refill_inst", inst, 32'h03020100);

    // Flush in IDLE, then the same address misses
    if_valid = 1'b1; if_addr = 32'h0000_1000; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_idle_done", {31'b0, if_done}, 32'h0);
    fetch(32'h0000_1000, inst, lat, fca);
    chk("flush_idle_lat", 32'(lat), 32'd5);

    // Flush on cycle 3 of a fill
    mem_lat = 5;
    f0 = fills;
    if_valid = 1'b1; if_addr = 32'h0000_3008;
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("drop_fc_valid", {31'b0, icache_fc_valid}, 32'h1);
    chk("drop_fc_addr", icache_fc_addr, 32'h0000_3000);
    wait_done(50, lat2);
    chk("drop_total_lat", 32'(lat2 + 4), 32'd15);
    chk("drop_fills", 32'(fills - f0), 32'd2);
    chk("drop_inst", if_inst, 32'hC0DE3008);
    if_valid = 1'b0;
    tick();

    // Flush coinciding with fc_done
    mem_lat = 3;
    f0 = fills;
    if_valid = 1'b1; if_addr = 32'h0000_4000;
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushdone_fc_valid", {31'b0, icache_fc_valid}, 32'h0);
    wait_done(50, lat2);
    chk("flushdone_fills", 32'(fills - f0), 32'd2);
    chk("flushdone_inst", if_inst, 32'hC0DE4000);
    if_valid = 1'b0;
    tick();

    // Request withdrawn during MISS: fill still written
    mem_lat = 2;
    if_valid = 1'b1; if_addr = 32'h0000_5000;
    tick();
    if_valid = 1'b0;
    lat = 0;
    while (icache_fc_valid && lat < 20) begin
      tick();
      lat++;
    end
    tick();
    fetch(32'h0000_5004, inst, lat, fca);
    chk("withdrawn_hit_lat", 32'(lat), 32'd1);
    chk("withdrawn_hit_inst", inst, 32'hC0DE5004);

    // Address changed during MISS
    f0 = fills;
    if_valid = 1'b1; if_addr = 32'h0000_6000;
    tick();
    if_addr = 32'h0000_7010;
    wait_done(50, lat2);
    chk("redirect_inst", if_inst, 32'hC0DE7010);
    chk("redirect_fills", 32'(fills - f0), 32'd2);
    if_valid = 1'b0;
    tick();
    fetch(32'h0000_6008, inst, lat, fca);
    chk("redirect_old_lat", 32'(lat), 32'd1);
    chk("redirect_old_inst", inst, 32'hC0DE6008);

    // Asynchronous reset mid-MISS
    fetch(32'h0000_1000, inst, lat, fca);
    fetch(32'h0000_1000, inst, lat, fca);
    chk("pre_reset_hit_lat", 32'(lat), 32'd1);
    mem_lat = 10;
    if_valid = 1'b1; if_addr = 32'h0000_8000;
    repeat (2) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_fc_valid", {31'b0, icache_fc_valid}, 32'h0);
    chk("async_if_done", {31'b0, if_done}, 32'h0);
    chk("async_if_inst", if_inst, 32'h0);
    tick();
    if_valid = 1'b0;
    tick();
    rst = 1'b0;
    mem_lat = 2;
    tick();
    fetch(32'h0000_1000, inst, lat, fca);
    chk("post_reset_lat", 32'(lat), 32'd5);
    chk("post_reset_inst", inst, 32'h03020100);

    repeat (3) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
